// File: rtl/alu_sequencer.sv
// Command/response sequencer for a bit-serial ALU over 11-bit start/type/data/stop frames.
// Define ALU_SEQ_CRC_CHECK_EN to build the response CRC3 check; otherwise rsp_crc_err is tied low.
module alu_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
  input  logic        req_bad_crc,
  output logic        sin,
  input  logic        sout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_c,
  output logic [7:0]  rsp_status,
  output logic        rsp_err,
  output logic        rsp_crc_err,
  output logic        rsp_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, TX, WAIT, RX, HOLD} state_e;

  state_e        state_q, state_d;
  logic [98:0]   txShift_q, txShift_d;
  logic [6:0]    bitCnt_q, bitCnt_d;
  logic [CW-1:0] waitCnt_q, waitCnt_d;
  logic [CW-1:0] waitInc;
  logic [2:0]    frameCnt_q, frameCnt_d;
  logic [7:0]    rxByte_q, rxByte_d;
  logic          rxType_q, rxType_d;
  logic [31:0]   rspC_q, rspC_d;
  logic [7:0]    status_q, status_d;
  logic          err_q, err_d;
  logic          timeout_q, timeout_d;

  function automatic logic [3:0] crc4(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2], c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  function automatic logic [10:0] frame(input logic ctl, input logic [7:0] data);
    return {1'b0, ctl, data, 1'b1};
  endfunction

  // The whole 9-frame command is serialised up front; TX just shifts it out MSB first.
  function automatic logic [98:0] buildTx(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic bad);
    logic [3:0] c;
    c = crc4({b, a, 1'b1, op});
    if (bad) c = ~c;
    return {frame(1'b0, b[31:24]), frame(1'b0, b[23:16]), frame(1'b0, b[15:8]),
            frame(1'b0, b[7:0]),   frame(1'b0, a[31:24]), frame(1'b0, a[23:16]),
            frame(1'b0, a[15:8]),  frame(1'b0, a[7:0]),   frame(1'b1, {1'b0, op, c})};
  endfunction

`ifdef ALU_SEQ_CRC_CHECK_EN
  logic crcErr_q, crcErr_d;

  function automatic logic [2:0] crc3(input logic [36:0] d);
    logic [2:0] c;
    logic       fb;
    c = '0;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    txShift_d  = txShift_q;
    bitCnt_d   = bitCnt_q;
    waitCnt_d  = waitCnt_q;
    frameCnt_d = frameCnt_q;
    rxByte_d   = rxByte_q;
    rxType_d   = rxType_q;
    rspC_d     = rspC_q;
    status_d   = status_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
`ifdef ALU_SEQ_CRC_CHECK_EN
    crcErr_d   = crcErr_q;
`endif
    waitInc    = waitCnt_q + CW'(1);
    sin        = 1'b1;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          txShift_d = buildTx(req_a, req_b, req_op, req_bad_crc);
          bitCnt_d  = '0;
          state_d   = TX;
        end
      end
      TX: begin
        sin       = txShift_q[98];
        txShift_d = {txShift_q[97:0], 1'b0};
        if (bitCnt_q == 7'd98) begin
          bitCnt_d  = '0;
          waitCnt_d = CW'(1);
          state_d   = WAIT;
        end else begin
          bitCnt_d = bitCnt_q + 7'd1;
        end
      end
      WAIT: begin
        if (!sout) begin
          bitCnt_d   = 7'd1;
          frameCnt_d = '0;
          waitCnt_d  = '0;
          state_d    = RX;
        end else if (waitInc == CW'(TIMEOUT_CYCLES)) begin
          waitCnt_d = '0;
          timeout_d = 1'b1;
          state_d   = HOLD;
        end else begin
          waitCnt_d = waitInc;
        end
      end
      RX: begin
        // bitCnt 0 means idle between frames, waiting for the next start bit.
        if (bitCnt_q == 7'd0) begin
          if (!sout) begin
            bitCnt_d  = 7'd1;
            waitCnt_d = '0;
          end else if (waitInc == CW'(TIMEOUT_CYCLES)) begin
            waitCnt_d = '0;
            rspC_d    = '0;
            timeout_d = 1'b1;
            state_d   = HOLD;
          end else begin
            waitCnt_d = waitInc;
          end
        end else if (bitCnt_q == 7'd1) begin
          rxType_d = sout;
          bitCnt_d = 7'd2;
        end else if (bitCnt_q <= 7'd9) begin
          rxByte_d = {rxByte_q[6:0], sout};
          bitCnt_d = bitCnt_q + 7'd1;
        end else begin
          bitCnt_d   = '0;
          rxByte_d   = '0;
          rxType_d   = 1'b0;
          frameCnt_d = frameCnt_q + 3'd1;
          if (!sout) begin
            rspC_d   = '0;
            status_d = 8'hFF;
            err_d    = 1'b1;
            state_d  = HOLD;
          end else if (frameCnt_q == 3'd0 && rxType_q && rxByte_q[7]) begin
            rspC_d   = '0;
            status_d = rxByte_q;
            err_d    = 1'b1;
            state_d  = HOLD;
          end else if (frameCnt_q < 3'd4) begin
            if (rxType_q) begin
              rspC_d   = '0;
              status_d = 8'hFF;
              err_d    = 1'b1;
              state_d  = HOLD;
            end else begin
              rspC_d = {rspC_q[23:0], rxByte_q};
            end
          end else if (!rxType_q) begin
            rspC_d   = '0;
            status_d = 8'hFF;
            err_d    = 1'b1;
            state_d  = HOLD;
          end else begin
            status_d = rxByte_q;
            state_d  = HOLD;
`ifdef ALU_SEQ_CRC_CHECK_EN
            crcErr_d = (crc3({rspC_q, 1'b0, rxByte_q[6:3]}) != rxByte_q[2:0]);
`endif
          end
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          rspC_d    = '0;
          status_d  = '0;
          err_d     = 1'b0;
          timeout_d = 1'b0;
`ifdef ALU_SEQ_CRC_CHECK_EN
          crcErr_d  = 1'b0;
`endif
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      txShift_q  <= '0;
      bitCnt_q   <= '0;
      waitCnt_q  <= '0;
      frameCnt_q <= '0;
      rxByte_q   <= '0;
      rxType_q   <= 1'b0;
      rspC_q     <= '0;
      status_q   <= '0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef ALU_SEQ_CRC_CHECK_EN
      crcErr_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      txShift_q  <= txShift_d;
      bitCnt_q   <= bitCnt_d;
      waitCnt_q  <= waitCnt_d;
      frameCnt_q <= frameCnt_d;
      rxByte_q   <= rxByte_d;
      rxType_q   <= rxType_d;
      rspC_q     <= rspC_d;
      status_q   <= status_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
`ifdef ALU_SEQ_CRC_CHECK_EN
      crcErr_q   <= crcErr_d;
`endif
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == HOLD);
  assign rsp_c       = rspC_q;
  assign rsp_status  = status_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = timeout_q;
`ifdef ALU_SEQ_CRC_CHECK_EN
  assign rsp_crc_err = crcErr_q;
`else
  assign rsp_crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: an ALU line model answers each command and a
// monitor compares every accepted response against the expectation queued at issue time.
module tb_alu_sequencer;

  localparam int Timeout = 30;
`ifdef ALU_SEQ_CRC_CHECK_EN
  localparam logic CrcEnabled = 1'b1;
`else
  localparam logic CrcEnabled = 1'b0;
`endif

  typedef enum int {ModeNormal, ModeCrcFlip, ModeErrFrame, ModeSilent, ModeBadStop, ModeBadType} mode_e;

  typedef struct {
    logic [31:0] c;
    logic [7:0]  status;
    logic        err;
    logic        crcErr;
    logic        timeout;
    logic        chkC;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqA, reqB;
  logic [2:0]  reqOp;
  logic        reqBadCrc;
  logic        sin, sout;
  logic        rspValid, rspReady;
  logic [31:0] rspC;
  logic [7:0]  rspStatus;
  logic        rspErr, rspCrcErr, rspTimeout;

  int   numChecks = 0;
  int   numFails  = 0;
  exp_t expQ[$];
  exp_t monExp;
  logic [2:0] opTable [4] = '{3'b000, 3'b001, 3'b100, 3'b101};

  alu_sequencer #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_ready(reqReady),
    .req_a(reqA), .req_b(reqB), .req_op(reqOp), .req_bad_crc(reqBadCrc),
    .sin(sin), .sout(sout),
    .rsp_valid(rspValid), .rsp_ready(rspReady),
    .rsp_c(rspC), .rsp_status(rspStatus),
    .rsp_err(rspErr), .rsp_crc_err(rspCrcErr), .rsp_timeout(rspTimeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // CRCs as remainders of polynomial long division (message shifted by the CRC width).
  function automatic logic [3:0] crc4Ref(input logic [67:0] msg);
    logic [71:0] r;
    r = {msg, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [2:0] crc3Ref(input logic [36:0] msg);
    logic [39:0] r;
    r = {msg, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic logic [31:0] aluRef(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b100:  return a + b;
      default: return a - b;
    endcase
  endfunction

  function automatic logic [98:0] txRef(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] op, input logic bad);
    logic [7:0]  bytes [9];
    logic [3:0]  crc;
    logic [98:0] v;
    crc = crc4Ref({b, a, 1'b1, op});
    if (bad) crc = ~crc;
    for (int i = 0; i < 4; i++) begin
      bytes[i]     = b[31 - 8*i -: 8];
      bytes[4 + i] = a[31 - 8*i -: 8];
    end
    bytes[8] = {1'b0, op, crc};
    v = '0;
    for (int f = 0; f < 9; f++) v = {v[87:0], 1'b0, (f == 8), bytes[f], 1'b1};
    return v;
  endfunction

  // ALU side of the line: optional idle gap, then one frame MSB first.
  task automatic driveFrame(input logic ctl, input logic [7:0] data, input logic stopBit, input int gap);
    logic [10:0] bits;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      sout = 1'b1;
    end
    bits = {1'b0, ctl, data, stopBit};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      sout = bits[i];
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                               input logic bad, input mode_e mode, input int gap, input int hold,
                               input logic [7:0] errByte);
    exp_t        e;
    logic [98:0] txGot, txExp;
    logic [31:0] c;
    logic [7:0]  st;
    logic [3:0]  nib;
    int          n, badCnt, flipBit;

    n = 0;
    while (!reqReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_ready_before_cmd", reqReady, 1);
    checkOutput("sin_idle", sin, 1);

    c       = aluRef(a, b, op);
    nib     = 4'($urandom_range(0, 15));
    st      = {1'b0, nib, crc3Ref({c, 1'b0, nib})};
    flipBit = $urandom_range(0, 2);
    e.c = c; e.status = st; e.err = 1'b0; e.crcErr = 1'b0; e.timeout = 1'b0; e.chkC = 1'b1;
    case (mode)
      ModeCrcFlip: begin
        st[flipBit] = ~st[flipBit];
        e.status = st;
        e.crcErr = CrcEnabled;
      end
      ModeErrFrame: begin
        e.c = '0; e.status = errByte; e.err = 1'b1;
      end
      ModeSilent: begin
        e.c = '0; e.status = '0; e.timeout = 1'b1;
      end
      ModeBadStop, ModeBadType: begin
        e.status = 8'hFF; e.err = 1'b1; e.chkC = 1'b0;
      end
      default: ;
    endcase

    reqA = a; reqB = b; reqOp = op; reqBadCrc = bad; reqValid = 1'b1;
    @(posedge clk);
    expQ.push_back(e);

    txExp = txRef(a, b, op, bad);
    for (int i = 98; i >= 0; i--) begin
      @(negedge clk);
      if (i == 98) reqValid = 1'b0;
      txGot[i] = sin;
    end
    checkOutput("tx_wrong_bit_count", $countones(txGot ^ txExp), 0);
    checkOutput("tx_ctl_frame", {21'b0, txGot[10:0]}, {21'b0, txExp[10:0]});
    checkOutput("tx_ctl_crc", {28'b0, txGot[4:1]},
                {28'b0, bad ? ~crc4Ref({b, a, 1'b1, op}) : crc4Ref({b, a, 1'b1, op})});

    if (mode == ModeSilent) begin
      n = 0;
      while (!rspValid && n < Timeout + 20) begin
        @(negedge clk);
        n++;
      end
      checkOutput("timeout_latency", n, Timeout);
    end else begin
      case (mode)
        ModeErrFrame: driveFrame(1'b1, errByte, 1'b1, gap);
        ModeBadStop: begin
          driveFrame(1'b0, c[31:24], 1'b1, gap);
          driveFrame(1'b0, c[23:16], 1'b0, 1);
        end
        ModeBadType: begin
          driveFrame(1'b0, c[31:24], 1'b1, gap);
          driveFrame(1'b1, 8'h00, 1'b1, 0);
        end
        default: begin
          for (int i = 0; i < 4; i++)
            driveFrame(1'b0, c[31 - 8*i -: 8], 1'b1, (i == 0) ? gap : int'($urandom_range(0, 3)));
          driveFrame(1'b1, st, 1'b1, $urandom_range(0, 3));
        end
      endcase
      n = 0;
      do begin
        @(negedge clk);
        sout = 1'b1;
        n++;
      end while (!rspValid && n < Timeout + 20);
      checkOutput("rsp_valid_rise", rspValid, 1);
    end

    badCnt = 0;
    for (int h = 0; h < hold; h++) begin
      if (!(rspValid && !reqReady && rspStatus == e.status && rspErr == e.err &&
            rspTimeout == e.timeout && rspCrcErr == e.crcErr && (!e.chkC || rspC == e.c)))
        badCnt++;
      @(negedge clk);
    end
    if (hold > 0) checkOutput("hold_stable", badCnt, 0);

    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput("req_ready_after_accept", reqReady, 1);
    checkOutput("rsp_valid_cleared", rspValid, 0);
    checkOutput("rsp_c_cleared", rspC, 0);
  endtask

  // Monitor: every response the consumer takes must match the oldest queued expectation.
  always @(negedge clk) begin
    #1;
    if (rspValid && rspReady && !rst) begin
      checkOutput("rsp_expected", expQ.size() > 0, 1);
      if (expQ.size() > 0) begin
        monExp = expQ.pop_front();
        if (monExp.chkC) checkOutput("rsp_c", rspC, monExp.c);
        checkOutput("rsp_status", rspStatus, monExp.status);
        checkOutput("rsp_err", rspErr, monExp.err);
        checkOutput("rsp_crc_err", rspCrcErr, monExp.crcErr);
        checkOutput("rsp_timeout", rspTimeout, monExp.timeout);
      end
    end
  end

  // Watchdog so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=expired required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int cnt;
    rst = 1'b1; reqValid = 1'b0; reqA = '0; reqB = '0; reqOp = '0; reqBadCrc = 1'b0;
    sout = 1'b1; rspReady = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sin", sin, 1);
    checkOutput("reset_req_ready", reqReady, 1);
    checkOutput("reset_rsp_valid", rspValid, 0);
    checkOutput("reset_rsp_c", rspC, 0);
    checkOutput("reset_rsp_status", rspStatus, 0);
    checkOutput("reset_rsp_err", rspErr, 0);
    checkOutput("reset_rsp_crc_err", rspCrcErr, 0);
    checkOutput("reset_rsp_timeout", rspTimeout, 0);
    rst = 1'b0;

    $display("[TB] directed add 1+2 with long hold");
    applyStimulus(32'd1, 32'd2, 3'b100, 1'b0, ModeNormal, 0, 20, 8'h00);

    $display("[TB] inverted command CRC with error frame A5");
    applyStimulus(32'd0, 32'd0, 3'b000, 1'b1, ModeErrFrame, 2, 1, 8'hA5);

    $display("[TB] silent ALU timeout");
    applyStimulus($urandom, $urandom, 3'b101, 1'b0, ModeSilent, 0, 2, 8'h00);

    $display("[TB] reset in the middle of TX");
    reqA = $urandom; reqB = $urandom; reqOp = 3'b001; reqBadCrc = 1'b0; reqValid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) reqValid = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("sin_after_reset", sin, 1);
    checkOutput("req_ready_after_reset", reqReady, 1);
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (rspValid) cnt++;
    end
    checkOutput("no_rsp_after_reset", cnt, 0);

    $display("[TB] randomized normal commands");
    for (int t = 0; t < 8; t++)
      applyStimulus($urandom, $urandom, opTable[$urandom_range(0, 3)], 1'b0, ModeNormal,
                    $urandom_range(0, 5), $urandom_range(0, 3), 8'h00);

    $display("[TB] response CRC3 corruption");
    for (int t = 0; t < 2; t++)
      applyStimulus($urandom, $urandom, opTable[$urandom_range(0, 3)], 1'b0, ModeCrcFlip,
                    $urandom_range(0, 5), 1, 8'h00);

    $display("[TB] malformed responses");
    applyStimulus($urandom, $urandom, 3'b100, 1'b0, ModeBadStop, 1, 1, 8'h00);
    applyStimulus($urandom, $urandom, 3'b000, 1'b0, ModeBadType, 0, 1, 8'h00);
    applyStimulus($urandom, $urandom, 3'b001, 1'b0, ModeErrFrame, 3, 0,
                  {1'b1, 7'($urandom_range(0, 127))});

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
